// File: rtl/chan_scan_pkg.sv
// rtl/chan_scan_pkg.sv - shared constants, state type and lowest-set-bit helper for the channel scanner
package chan_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/chan_next_find.sv
// rtl/chan_next_find.sv - next enabled channel above cur (mod NUM_CH) and pass-wrap flag
module chan_next_find
    import chan_scan_pkg::*;
(
    input  logic [SEL_W-1:0]  cur,
    input  logic [NUM_CH-1:0] mask,
    output logic [SEL_W-1:0]  nxt,
    output logic              wrap
);

    logic             found;
    logic [SEL_W-1:0] idx;

    // With no other enabled channel the scan stays on cur, which counts as a wrap.
    always_comb begin
        nxt   = cur;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i < NUM_CH; i++) begin
            idx = cur + SEL_W'(i);
            if (!found && mask[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
        wrap = (nxt <= cur);
    end

endmodule

// File: rtl/chan_scan_ctrl.sv
// rtl/chan_scan_ctrl.sv - channel-scan controller; CHAN_SCAN_MASK_EN adds the ch_mask port
module chan_scan_ctrl
    import chan_scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_cont,
    input  logic [DWELL_W-1:0] dwell,
`ifdef CHAN_SCAN_MASK_EN
    input  logic [NUM_CH-1:0]  ch_mask,
`endif
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               wrap,
    output logic               done
);

    scan_state_t        state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               sel_valid_q, sel_valid_d;
    logic               busy_q, busy_d;
    logic               wrap_q, wrap_d;
    logic               done_q, done_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_lat_q, dwell_lat_d;
    logic               mode_q, mode_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic [NUM_CH-1:0]  mask_in;
    logic [SEL_W-1:0]   nf_nxt;
    logic               nf_wrap;

`ifdef CHAN_SCAN_MASK_EN
    assign mask_in = ch_mask;
`else
    assign mask_in = '1;
`endif

    chan_next_find u_next (
        .cur  (sel_q),
        .mask (mask_q),
        .nxt  (nf_nxt),
        .wrap (nf_wrap)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        busy_d      = busy_q;
        wrap_d      = 1'b0;
        done_d      = 1'b0;
        cnt_d       = cnt_q;
        dwell_lat_d = dwell_lat_q;
        mode_d      = mode_q;
        mask_d      = mask_q;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    mode_d      = mode_cont;
                    dwell_lat_d = dwell;
                    mask_d      = mask_in;
                    if (mask_in != '0) begin
                        sel_d       = lowest_set(mask_in);
                        cnt_d       = dwell;
                        state_d     = SCAN;
                        sel_valid_d = 1'b1;
                        busy_d      = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (stop) begin
                    state_d     = IDLE;
                    sel_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                end else if (cnt_q == '0) begin
                    // End of a one-shot pass leaves sel on the last channel shown.
                    if (nf_wrap && !mode_q) begin
                        state_d     = IDLE;
                        sel_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        sel_d  = nf_nxt;
                        cnt_d  = dwell_lat_q;
                        wrap_d = nf_wrap;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            dwell_lat_q <= '0;
            mode_q      <= 1'b0;
            mask_q      <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            busy_q      <= busy_d;
            wrap_q      <= wrap_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            dwell_lat_q <= dwell_lat_d;
            mode_q      <= mode_d;
            mask_q      <= mask_d;
        end
    end

    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;
    assign busy      = busy_q;
    assign wrap      = wrap_q;
    assign done      = done_q;

endmodule
